// File: rtl/idli_sqi_rd_buf_m.sv
// idli_sqi_rd_buf_m: assembles big-endian SQI read nibbles into 16b words and replays them little-endian.
// Optional sticky overflow flag enabled by defining IDLI_SQI_RD_BUF_OVF_EN.
module idli_sqi_rd_buf_m #(
    parameter int DEPTH = 2
) (
    input  logic                     i_rdb_gck,
    input  logic                     i_rdb_rst,
    input  logic [1:0]               i_rdb_ctr,
    input  logic                     i_rdb_capture,
    input  logic [3:0]               i_rdb_sqi_data,
    input  logic                     i_rdb_flush,
    input  logic                     i_rdb_rd,
    output logic [3:0]               o_rdb_data,
    output logic                     o_rdb_vld,
    output logic [$clog2(DEPTH):0]   o_rdb_cnt,
    output logic                     o_rdb_ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   asm_q, asm_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   word;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          push, pop, rd_ok, full, acc;

    assign word      = {asm_q[15:4], i_rdb_sqi_data};
    assign full      = cnt_q == (AW+1)'(DEPTH);
    assign o_rdb_vld = cnt_q != '0;
    assign push      = i_rdb_capture && i_rdb_ctr == 2'd3 && !i_rdb_flush;
    assign rd_ok     = i_rdb_rd && o_rdb_vld && !i_rdb_flush;
    assign pop       = rd_ok && idx_q == 2'd3;
    // A final-nibble pop frees a slot in the same edge, so a push onto a full FIFO still lands.
    assign acc       = push && (!full || pop);

    always_comb begin
        asm_d = asm_q;
        if (i_rdb_capture)
            asm_d[{~i_rdb_ctr, 2'b00} +: 4] = i_rdb_sqi_data;
    end

    always_comb begin
        wr_d  = i_rdb_flush ? '0 : acc ? wr_q + AW'(1) : wr_q;
        rd_d  = i_rdb_flush ? '0 : pop ? rd_q + AW'(1) : rd_q;
        idx_d = i_rdb_flush ? 2'd0 : rd_ok ? idx_q + 2'd1 : idx_q;
        cnt_d = i_rdb_flush ? '0 : cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
    end

    always_ff @(posedge i_rdb_gck) begin
        asm_q <= asm_d;
        if (acc && !i_rdb_rst)
            mem_q[wr_q] <= word;
    end

    always_ff @(posedge i_rdb_gck) begin
        if (i_rdb_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

`ifdef IDLI_SQI_RD_BUF_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q | (push && full && !pop);

    always_ff @(posedge i_rdb_gck) begin
        if (i_rdb_rst)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign o_rdb_ovf = ovf_q;
`else
    assign o_rdb_ovf = 1'b0;
`endif

    assign o_rdb_cnt  = cnt_q;
    assign o_rdb_data = mem_q[rd_q][{idx_q, 2'b00} +: 4];
endmodule

// File: tb/tb_idli_sqi_rd_buf_m.sv
// tb_idli_sqi_rd_buf_m: directed checks of capture, fill/drop, simultaneous pop, flush and reset.
module tb_idli_sqi_rd_buf_m;
`ifdef IDLI_SQI_RD_BUF_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] ctr = 2'd0;
    logic       capture = 1'b0;
    logic [3:0] sqi_data = 4'd0;
    logic       flush = 1'b0;
    logic       rd = 1'b0;
    logic [3:0] data;
    logic       vld;
    logic [1:0] cnt;
    logic       ovf;
    int         errors = 0;
    int         checks = 0;

    idli_sqi_rd_buf_m #(.DEPTH(2)) dut (
        .i_rdb_gck      (clk),
        .i_rdb_rst      (rst),
        .i_rdb_ctr      (ctr),
        .i_rdb_capture  (capture),
        .i_rdb_sqi_data (sqi_data),
        .i_rdb_flush    (flush),
        .i_rdb_rd       (rd),
        .o_rdb_data     (data),
        .o_rdb_vld      (vld),
        .o_rdb_cnt      (cnt),
        .o_rdb_ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w, input logic rd_last, input logic fl_last, input logic rst_last);
        for (int c = 0; c < 4; c++) begin
            ctr      = 2'(c);
            capture  = 1'b1;
            sqi_data = w[(15 - 4*c) -: 4];
            if (c == 3) begin
                rd    = rd_last;
                flush = fl_last;
                rst   = rst_last;
            end
            tick();
        end
        capture = 1'b0;
        rd      = 1'b0;
        flush   = 1'b0;
        rst     = 1'b0;
        ctr     = 2'd0;
    endtask

    task automatic rd_nib(input string tag, input logic [3:0] e);
        chk({tag, "_vld"}, 16'(vld), 16'd1);
        chk(tag, 16'(data), 16'(e));
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        // basic capture and LE replay
        do_reset();
        chk("rst_cnt", 16'(cnt), 16'd0);
        chk("rst_vld", 16'(vld), 16'd0);
        chk("rst_ovf", 16'(ovf), 16'd0);
        push_word(16'h1234, 1'b0, 1'b0, 1'b0);
        chk("basic_cnt", 16'(cnt), 16'd1);
        rd_nib("basic_n0", 4'h4);
        rd_nib("basic_n1", 4'h3);
        rd_nib("basic_n2", 4'h2);
        rd_nib("basic_n3", 4'h1);
        chk("basic_vld_end", 16'(vld), 16'd0);
        chk("basic_cnt_end", 16'(cnt), 16'd0);

        // fill and drop
        push_word(16'hABCD, 1'b0, 1'b0, 1'b0);
        push_word(16'h1234, 1'b0, 1'b0, 1'b0);
        chk("fill_cnt", 16'(cnt), 16'd2);
        chk("fill_ovf0", 16'(ovf), 16'd0);
        push_word(16'h5555, 1'b0, 1'b0, 1'b0);
        chk("drop_cnt", 16'(cnt), 16'd2);
        chk("drop_ovf", 16'(ovf), 16'(OVF_EN));
        rd_nib("fill_n0", 4'hD);
        rd_nib("fill_n1", 4'hC);
        rd_nib("fill_n2", 4'hB);
        rd_nib("fill_n3", 4'hA);
        chk("fill_cnt1", 16'(cnt), 16'd1);
        rd_nib("fill_n4", 4'h4);
        rd_nib("fill_n5", 4'h3);
        rd_nib("fill_n6", 4'h2);
        rd_nib("fill_n7", 4'h1);
        chk("fill_cnt_end", 16'(cnt), 16'd0);

        // full with simultaneous final-nibble pop
        do_reset();
        push_word(16'hABCD, 1'b0, 1'b0, 1'b0);
        push_word(16'h1234, 1'b0, 1'b0, 1'b0);
        rd_nib("sim_n0", 4'hD);
        rd_nib("sim_n1", 4'hC);
        rd_nib("sim_n2", 4'hB);
        chk("sim_n3", 16'(data), 16'hA);
        push_word(16'h9876, 1'b1, 1'b0, 1'b0);
        chk("sim_cnt", 16'(cnt), 16'd2);
        chk("sim_ovf", 16'(ovf), 16'd0);
        rd_nib("sim_n4", 4'h4);
        rd_nib("sim_n5", 4'h3);
        rd_nib("sim_n6", 4'h2);
        rd_nib("sim_n7", 4'h1);
        rd_nib("sim_n8", 4'h6);
        rd_nib("sim_n9", 4'h7);
        rd_nib("sim_n10", 4'h8);
        rd_nib("sim_n11", 4'h9);
        chk("sim_cnt_end", 16'(cnt), 16'd0);

        // flush overrides rd and push
        push_word(16'hABCD, 1'b0, 1'b0, 1'b0);
        push_word(16'h1234, 1'b0, 1'b0, 1'b0);
        rd_nib("fl_n0", 4'hD);
        rd_nib("fl_n1", 4'hC);
        push_word(16'h5678, 1'b1, 1'b1, 1'b0);
        chk("fl_cnt", 16'(cnt), 16'd0);
        chk("fl_vld", 16'(vld), 16'd0);
        push_word(16'h0F0F, 1'b0, 1'b0, 1'b0);
        chk("fl_cnt1", 16'(cnt), 16'd1);
        rd_nib("fl_n2", 4'hF);
        rd_nib("fl_n3", 4'h0);
        rd_nib("fl_n4", 4'hF);
        rd_nib("fl_n5", 4'h0);
        chk("fl_cnt_end", 16'(cnt), 16'd0);

        // reset with pending push and overflow
        do_reset();
        push_word(16'hABCD, 1'b0, 1'b0, 1'b0);
        push_word(16'h1234, 1'b0, 1'b0, 1'b0);
        push_word(16'h5555, 1'b0, 1'b0, 1'b0);
        rd_nib("rs_n0", 4'hD);
        rd_nib("rs_n1", 4'hC);
        rd_nib("rs_n2", 4'hB);
        rd_nib("rs_n3", 4'hA);
        chk("rs_cnt_pre", 16'(cnt), 16'd1);
        chk("rs_ovf_pre", 16'(ovf), 16'(OVF_EN));
        push_word(16'h7777, 1'b0, 1'b0, 1'b1);
        chk("rs_cnt", 16'(cnt), 16'd0);
        chk("rs_vld", 16'(vld), 16'd0);
        chk("rs_ovf", 16'(ovf), 16'd0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("rs_rd_cnt", 16'(cnt), 16'd0);
        chk("rs_rd_vld", 16'(vld), 16'd0);
        chk("rs_rd_ovf", 16'(ovf), 16'd0);
        push_word(16'hCAFE, 1'b0, 1'b0, 1'b0);
        rd_nib("rs_n4", 4'hE);
        rd_nib("rs_n5", 4'hF);
        rd_nib("rs_n6", 4'hA);
        rd_nib("rs_n7", 4'hC);
        chk("rs_cnt_end", 16'(cnt), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/idli_sqi_rd_buf_m.md
IDLI_SQI_RD_BUF_M -- requirements
Module: idli_sqi_rd_buf_m

Purpose: sits downstream of the SQI controller. It collects big-endian read nibbles from the memory pins into 16b words, queues them, and presents them to the core nibble-serially in little-endian order.

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the word FIFO depth; legal values are powers of two, minimum 2.
REQ-002 The block SHALL have port i_rdb_gck, input, 1 bit: the core clock (single clock domain).
REQ-003 The block SHALL have port i_rdb_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_rdb_ctr, input, 2 bits: nibble position within the current 4-cycle 16b period.
REQ-005 The block SHALL have port i_rdb_capture, input, 1 bit: the memory is driving valid read data on this cycle (controller in DATA state, read mode).
REQ-006 The block SHALL have port i_rdb_sqi_data, input, 4 bits: read nibble from the SQI pins.
REQ-007 The block SHALL have port i_rdb_flush, input, 1 bit: redirect; discard all buffered and partial data.
REQ-008 The block SHALL have port i_rdb_rd, input, 1 bit: the core consumes the current output nibble.
REQ-009 The block SHALL have port o_rdb_data, output, 4 bits: current LE nibble of the head word.
REQ-010 The block SHALL have port o_rdb_vld, output, 1 bit: o_rdb_data is valid (FIFO not empty).
REQ-011 The block SHALL have port o_rdb_cnt, output, clog2(DEPTH)+1 bits: number of complete words held.
REQ-012 The block SHALL have port o_rdb_ovf, output, 1 bit: sticky overflow flag (see Configuration).

Function
REQ-013 On a cycle with i_rdb_capture=1, the block SHALL write i_rdb_sqi_data into assembly register bits [15-4*ctr : 12-4*ctr] (ctr 0 maps to bits 15:12, big-endian).
REQ-014 On a cycle with i_rdb_capture=1 and ctr=3, the block SHALL push {assembly[15:4], i_rdb_sqi_data} to the FIFO tail at that clock edge; o_rdb_vld and o_rdb_cnt SHALL reflect the push on the next cycle.
REQ-015 Capture with ctr=0..2 SHALL NOT push; a word in which capture was low for some nibbles SHALL still push on ctr=3 capture, keeping the stale nibbles (the controller guarantees contiguity).
REQ-016 o_rdb_vld SHALL equal (o_rdb_cnt != 0); o_rdb_data SHALL be bits [4*idx+3 : 4*idx] of the head word, where idx is the 2-bit output nibble index (LE: bits 3:0 first).
REQ-017 i_rdb_rd with o_rdb_vld=1 SHALL increment idx modulo 4; at idx=3 it SHALL also pop the head word, and idx SHALL wrap to 0.
REQ-018 i_rdb_rd with o_rdb_vld=0 SHALL be ignored, with no state change.
REQ-019 A push and a final-nibble pop in the same cycle SHALL both take effect; o_rdb_cnt SHALL be unchanged. This holds when full: the push is accepted.
REQ-020 A push when full without a simultaneous final-nibble pop SHALL drop the word; FIFO contents and o_rdb_cnt SHALL be unchanged.
REQ-021 Head and tail pointers SHALL wrap modulo DEPTH; o_rdb_cnt SHALL range from 0 to DEPTH.
REQ-022 i_rdb_flush=1 SHALL, at the edge, set cnt, pointers and idx to 0; it SHALL override capture, push and rd in the same cycle; the assembly register need not be cleared; o_rdb_ovf SHALL be unaffected.
REQ-023 o_rdb_data SHALL be don't-care while o_rdb_vld=0.

Reset
REQ-024 While i_rdb_rst=1 at a clock edge, the block SHALL clear pointers, o_rdb_cnt, idx and o_rdb_ovf to 0, giving o_rdb_vld=0 from the following cycle; reset SHALL take priority over flush, capture and rd.
REQ-025 The FIFO storage and assembly register SHALL NOT be reset.
REQ-026 Reset asserted mid-word SHALL discard the partial word; capture resumes at the next ctr=0 after reset.

Configuration
REQ-027 The macro IDLI_SQI_RD_BUF_OVF_EN SHALL control the overflow flag.
REQ-028 With IDLI_SQI_RD_BUF_OVF_EN defined, o_rdb_ovf SHALL set on any dropped push (REQ-020) and SHALL stay set until reset.
REQ-029 Without IDLI_SQI_RD_BUF_OVF_EN, o_rdb_ovf SHALL be constant 0, no flag register SHALL exist, and drop behaviour SHALL be unchanged.

Verification
REQ-030 Basic capture: capture nibbles 0x1,0x2,0x3,0x4 with ctr=0..3, then rd every cycle -> one cycle after the push o_rdb_vld=1, cnt=1; outputs in order 0x4,0x3,0x2,0x1; then vld=0, cnt=0.
REQ-031 Fill (DEPTH=2): push words 0xABCD and 0x1234 with no rd -> cnt=2; the third word 0x5555 is dropped; ovf=1 when the macro is defined, 0 otherwise; reading yields D,C,B,A,4,3,2,1.
REQ-032 Full with simultaneous pop: DEPTH=2 full, idx=3; rd asserted on the same cycle as the ctr=3 push of 0x9876 -> cnt stays 2, ovf stays 0, 0x9876 is read out last.
REQ-033 Flush: with cnt=2 and idx=2, assert flush together with rd and a ctr=3 push -> next cycle cnt=0, vld=0, idx=0; a subsequent fresh word 0x0F0F reads F,0,F,0.
REQ-034 Reset: with cnt=1 and ovf=1, assert rst for one cycle concurrently with a push -> next cycle cnt=0, vld=0, ovf=0; rd while empty leaves all state at 0.
